// File: rtl/pc_gen.sv
// pc_gen: registered fetch program counter with exception/eret vectors and a
//    pending-redirect latch that keeps branch/jump decisions made during stalls.
// Latency: redirect, exc and eret appear on pc one cycle after they are sampled.
//    A redirect seen while stalled appears one cycle after the first unstalled cycle.
// Backpressure: stall holds pc and captures any redirect; exc/eret ignore stall.
//
// Ports:
//    clk, reset             single clock, synchronous active-high reset
//    stall                  hold pc (fetch/decode stalled)
//    br_take/j_take/jr_take redirect requests from ID (priority jr > j > br)
//    br_pc, imm, jr_target  operands used to form the redirect target
//    exc, eret, epc         CP0 commits: handler entry / return to epc
//    pc                     registered fetch address
//    pend_valid             a redirect is latched, waiting for stall release
//    fetch_adel             pc misaligned or outside the instruction window
module pc_gen #(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_3000,
   parameter logic [PC_W-1:0] EXC_PC    = 32'h0000_4180,
   parameter logic [PC_W-1:0] IMEM_BASE = 32'h0000_3000,
   parameter logic [PC_W-1:0] IMEM_SIZE = 32'h0000_2000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            br_take,
   input  logic            j_take,
   input  logic            jr_take,
   input  logic [PC_W-1:0] br_pc,
   input  logic [25:0]     imm,
   input  logic [PC_W-1:0] jr_target,
   input  logic            exc,
   input  logic            eret,
   input  logic [PC_W-1:0] epc,
   output logic [PC_W-1:0] pc,
   output logic            pend_valid,
   output logic            fetch_adel
);

   logic [PC_W-1:0] bp4;
   logic [PC_W-1:0] br_off;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pend_target;
   logic            redirect;
   logic [PC_W:0]   imem_limit;

   assign bp4      = br_pc + PC_W'(4);
   // Sign-extended word offset of the 16-bit branch displacement.
   assign br_off   = {{(PC_W-18){imm[15]}}, imm[15:0], 2'b00};
   assign redirect = br_take | j_take | jr_take;

   always_comb begin
      target = bp4 + br_off;
      if (jr_take) begin
         target = jr_target;
      end else if (j_take) begin
         target = {bp4[PC_W-1:28], imm, 2'b00};
      end
   end

   // One extra bit so a window ending at the top of the address space
   // does not wrap to zero.
   assign imem_limit = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

   assign fetch_adel = (pc[1:0] != 2'b00)
                     | (pc < IMEM_BASE)
                     | ({1'b0, pc} >= imem_limit);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_target <= RESET_PC;
      end else if (exc) begin
         pc         <= EXC_PC;
         pend_valid <= 1'b0;
      end else if (eret) begin
         pc         <= epc;
         pend_valid <= 1'b0;
      end else if (stall) begin
         // pc holds; the newest redirect overwrites any older pending one.
         if (redirect) begin
            pend_target <= target;
            pend_valid  <= 1'b1;
         end
      end else if (redirect) begin
         // A live redirect is younger than anything pending, so it wins.
         pc         <= target;
         pend_valid <= 1'b0;
      end else if (pend_valid) begin
         pc         <= pend_target;
         pend_valid <= 1'b0;
      end else begin
         pc <= pc + PC_W'(4);
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        reset, stall, br_take, j_take, jr_take, exc, eret;
   logic [31:0] br_pc, jr_target, epc;
   logic [25:0] imm;
   logic [31:0] pc;
   logic        pend_valid, fetch_adel;

   int checks   = 0;
   int failures = 0;

   // Reference state: the architectural pc and a queue holding at most one
   // pending redirect target.
   longint unsigned m_pc;
   longint unsigned m_pend[$];

   always #5 clk = ~clk;

   pc_gen dut (
      .clk(clk), .reset(reset), .stall(stall),
      .br_take(br_take), .j_take(j_take), .jr_take(jr_take),
      .br_pc(br_pc), .imm(imm), .jr_target(jr_target),
      .exc(exc), .eret(eret), .epc(epc),
      .pc(pc), .pend_valid(pend_valid), .fetch_adel(fetch_adel)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint unsigned ref_target();
      longint unsigned bp4, off;
      longint signed   disp;
      bp4 = (longint'(br_pc) + 4) % 64'h1_0000_0000;
      if (jr_take) return longint'(jr_target);
      if (j_take)  return (bp4 / 64'h1000_0000) * 64'h1000_0000 + longint'(imm) * 4;
      disp = (imm[15:0] >= 16'h8000) ? longint'(imm[15:0]) - 65536 : longint'(imm[15:0]);
      off  = longint'(disp * 4);
      return (bp4 + off) % 64'h1_0000_0000;
   endfunction

   function automatic logic ref_adel(input longint unsigned a);
      return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 64'h2000);
   endfunction

   // Advance the model by the rules for this edge, clock the DUT, compare.
   task automatic cycle(input string tag);
      logic redir;
      redir = br_take | j_take | jr_take;
      if (reset) begin
         m_pc = 64'h3000; m_pend.delete();
      end else if (exc) begin
         m_pc = 64'h4180; m_pend.delete();
      end else if (eret) begin
         m_pc = longint'(epc); m_pend.delete();
      end else if (stall) begin
         if (redir) begin
            m_pend.delete(); m_pend.push_back(ref_target());
         end
      end else if (redir) begin
         m_pc = ref_target(); m_pend.delete();
      end else if (m_pend.size() != 0) begin
         m_pc = m_pend.pop_front();
      end else begin
         m_pc = (m_pc + 4) % 64'h1_0000_0000;
      end
      @(posedge clk);
      #1;
      check({tag, ".pc"},   pc,                 32'(m_pc));
      check({tag, ".pend"}, 32'(pend_valid),    32'(m_pend.size() != 0));
      check({tag, ".adel"}, 32'(fetch_adel),    32'(ref_adel(m_pc)));
      br_take = 1'b0; j_take = 1'b0; jr_take = 1'b0; exc = 1'b0; eret = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; br_take = 1'b0; j_take = 1'b0; jr_take = 1'b0;
      exc = 1'b0; eret = 1'b0; br_pc = '0; imm = '0; jr_target = '0; epc = '0;
      #2;
      cycle("reset");
      check("reset_pc", pc, 32'h3000);
      reset = 1'b0;
      cycle("run1"); cycle("run2"); cycle("run3");
      check("run_pc", pc, 32'h300C);

      // Branch backward then forward.
      br_take = 1'b1; br_pc = 32'h3010; imm = 26'h000FFFC; cycle("br_back");
      check("br_back_pc", pc, 32'h3004);
      br_take = 1'b1; br_pc = 32'h3010; imm = 26'h0000003; cycle("br_fwd");
      check("br_fwd_pc", pc, 32'h3020);

      // Jump, then jump and jr together (jr wins).
      j_take = 1'b1; br_pc = 32'h3000; imm = 26'h0000C40; cycle("j");
      check("j_pc", pc, 32'h3100);
      j_take = 1'b1; jr_take = 1'b1; jr_target = 32'h3400; cycle("jr_prio");
      check("jr_prio_pc", pc, 32'h3400);

      // Redirects during stall: newest pending wins after release.
      stall = 1'b1;
      br_take = 1'b1; br_pc = 32'h3030; imm = 26'h0000003; cycle("st1");
      check("st1_pend", 32'(pend_valid), 32'd1);
      jr_take = 1'b1; jr_target = 32'h3080; cycle("st2");
      cycle("st3");
      check("st_hold", pc, 32'h3400);
      stall = 1'b0; cycle("st_rel");
      check("st_rel_pc", pc, 32'h3080);
      check("st_rel_pend", 32'(pend_valid), 32'd0);

      // exc beats stall and clears pending; then eret.
      stall = 1'b1; br_take = 1'b1; cycle("pre_exc");
      exc = 1'b1; cycle("exc");
      check("exc_pc", pc, 32'h4180);
      check("exc_pend", 32'(pend_valid), 32'd0);
      stall = 1'b0; eret = 1'b1; epc = 32'h3024; cycle("eret");
      check("eret_pc", pc, 32'h3024);

      // Address error flag.
      jr_take = 1'b1; jr_target = 32'h3002; cycle("mis");
      check("mis_adel", 32'(fetch_adel), 32'd1);
      jr_take = 1'b1; jr_target = 32'h5000; cycle("oor");
      check("oor_adel", 32'(fetch_adel), 32'd1);
      jr_take = 1'b1; jr_target = 32'h4FFC; cycle("edge_in");
      check("edge_in_adel", 32'(fetch_adel), 32'd0);
      cycle("edge_out");
      check("edge_out_pc", pc, 32'h5000);
      check("edge_out_adel", 32'(fetch_adel), 32'd1);
      reset = 1'b1; cycle("rst_adel");
      check("rst_adel_pc", pc, 32'h3000);
      check("rst_adel_adel", 32'(fetch_adel), 32'd0);
      reset = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         exc       = ($urandom_range(0, 39) == 0);
         eret      = ($urandom_range(0, 39) == 0);
         stall     = ($urandom_range(0, 2) == 0);
         br_take   = ($urandom_range(0, 5) == 0);
         j_take    = ($urandom_range(0, 9) == 0);
         jr_take   = ($urandom_range(0, 9) == 0);
         br_pc     = 32'h3000 + 32'($urandom_range(0, 32'h2000));
         if ($urandom_range(0, 7) == 0) br_pc = $urandom();
         imm       = 26'($urandom());
         jr_target = ($urandom_range(0, 3) == 0) ? $urandom()
                                                 : 32'h2FF0 + 32'($urandom_range(0, 32'h2020));
         epc       = 32'h3000 + 32'($urandom_range(0, 32'h1FFF));
         cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch-stage program-counter generator for the pipelined MIPS core, superseding the combinational next-PC mux with a registered PC. It adds a parametrised reset and exception vector, an EPC return path, and a pending-redirect latch so that branch/jump decisions made while fetch is stalled are not lost. It also flags misaligned or out-of-range fetch addresses. It sits between the ID-stage branch comparator/CP0 and the instruction memory address port.

## Interface
- PC_W, 32: PC width; all address ports use this width
- RESET_PC, 32'h0000_3000: PC value after reset
- EXC_PC, 32'h0000_4180: exception handler entry
- IMEM_BASE, 32'h0000_3000: lowest legal fetch address
- IMEM_SIZE, 32'h0000_2000: legal fetch window size in bytes
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC (fetch/decode stalled)
- br_take  in  1  conditional branch resolved taken in ID
- j_take  in  1  j/jal in ID
- jr_take  in  1  jr/jalr in ID
- br_pc  in  PC_W  PC of the branch/jump instruction in ID
- imm  in  26  instr[25:0]; branches use imm[15:0]
- jr_target  in  PC_W  forwarded register value for jr/jalr
- exc  in  1  exception/interrupt commit from CP0
- eret  in  1  eret commit
- epc  in  PC_W  return address for eret
- pc  out  PC_W  registered fetch PC
- pend_valid  out  1  redirect latched, waiting for stall release
- fetch_adel  out  1  current pc misaligned or outside fetch window

## Operation
- Redirect target (combinational, the target captured when a redirect fires):
  - jr_take: jr_target.
  - Else j_take: {bp4[PC_W-1:28], imm, 2'b00}, where bp4 = br_pc+4.
  - Else br_take: bp4 + (sign-extended imm[15:0] << 2), modulo 2^PC_W.
  - Priority if several are asserted: jr > j > br.
- Next-PC priority each edge, highest first:
  1. reset: pc=RESET_PC, pend_valid=0.
  2. exc: pc=EXC_PC, pend_valid=0. Ignores stall.
  3. eret: pc=epc, pend_valid=0. Ignores stall.
  4. stall=1:
     - pc holds.
     - If any redirect is asserted, pend_target=target and pend_valid=1. A newer redirect overwrites an older pending one.
  5. stall=0, redirect asserted: pc=target, pend_valid=0. A live redirect beats a pending one.
  6. stall=0, pend_valid=1: pc=pend_target, pend_valid=0.
  7. Otherwise: pc=pc+4, wrapping modulo 2^PC_W.
- fetch_adel:
  - Combinational on pc.
  - Asserted when pc[1:0]!=0, or pc<IMEM_BASE, or pc>=IMEM_BASE+IMEM_SIZE.
  - PC still advances normally; CP0 decides on the exception.
- Reset mid-operation discards any pending redirect.

## Timing
- Reset values: pc=RESET_PC, pend_valid=0, fetch_adel=0 with default parameters.
- Latency:
  - Redirect with stall=0: new pc visible 1 cycle after the redirect cycle.
  - Redirect during stall: new pc visible 1 cycle after the first stall=0 cycle.
  - exc/eret: always 1 cycle, regardless of stall.
- Redirect inputs are sampled only on the edge where they are asserted; upstream holds them one cycle per decision.
- pend_valid is registered and rises the edge after a stalled redirect.

## Test plan
- Reset, then 3 free-running cycles: pc = 0x3000, 0x3004, 0x3008, 0x300C; pend_valid=0; fetch_adel=0.
- br_take with br_pc=0x3010, imm[15:0]=0xFFFC, stall=0: next pc = 0x3004. Then with imm[15:0]=0x0003: next pc = 0x3020.
- j_take with br_pc=0x3000, imm=0x0000C40, stall=0: pc = 0x0000_3100. In the same cycle as jr_take with jr_target=0x3400: pc = 0x3400 (jr wins).
- stall=1 for 3 cycles with br_take pulsed in cycle 1 (target 0x3040) and jr_take in cycle 2 (target 0x3080): pc holds; pend_valid=1 from cycle 2; after stall drops pc=0x3080 and pend_valid=0.
- exc with stall=1 and pend_valid=1: pc=0x4180 next cycle, pend_valid=0. Then eret with epc=0x3024: pc=0x3024.
- jr_target=0x3002: fetch_adel=1. jr_target=0x5000: fetch_adel=1. Free-run from 0x4FFC: 0x4FFC has fetch_adel=0, next pc 0x5000 has fetch_adel=1. Reset while fetch_adel=1: pc=0x3000, fetch_adel=0.
